// File: rtl/fifo_flag_checker.sv
// Multi-channel FIFO status-flag checker: per-channel occupancy model compared
// against DUT flags, with registered error pulse, sticky bits and error count.

module fifo_flag_checker_ch #(
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 2**ASIZE-2,
    parameter int AEMPTY_TH = 2,
    parameter int FLAG_LAT  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_chk_en,
    input  logic             i_wen,
    input  logic             i_ren,
    input  logic [5:0]       i_dut,
    output logic [ASIZE:0]   o_occ,
    output logic [5:0]       o_mis
);
    localparam logic [ASIZE:0] DEPTH = (ASIZE+1)'(2**ASIZE);
    localparam logic [ASIZE:0] AF    = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AE    = (ASIZE+1)'(AEMPTY_TH);
    // Expectation for an idle, empty FIFO; bit order {unf, ovf, ne, e, nf, f}.
    localparam logic [5:0] RST_EXP = {2'b00, (AEMPTY_TH >= 0), 1'b1, (AFULL_TH <= 0), 1'b0};

    logic [ASIZE:0] r_occ;
    logic [ASIZE:0] w_occ_nxt;
    logic           w_full;
    logic           w_empty;
    logic           w_wr;
    logic           w_rd;
    logic [5:0]     w_exp;
    logic [5:0]     w_cmp;

    always_comb begin
        w_full    = (r_occ == DEPTH);
        w_empty   = (r_occ == '0);
        w_wr      = i_wen & ~w_full;
        w_rd      = i_ren & ~w_empty;
        w_occ_nxt = r_occ + (ASIZE+1)'(w_wr) - (ASIZE+1)'(w_rd);
        w_exp     = {i_ren & w_empty, i_wen & w_full, (r_occ <= AE), w_empty, (r_occ >= AF), w_full};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_occ <= '0;
        else       r_occ <= w_occ_nxt;
    end

    generate
        if (FLAG_LAT == 1) begin : g_lat1
            // Pipeline resets to the idle expectation so the first compare after
            // reset sees empty/near_empty set rather than a spurious all-zero vector.
            logic [5:0] r_exp;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) r_exp <= RST_EXP;
                else       r_exp <= w_exp;
            end
            assign w_cmp = r_exp;
        end else begin : g_lat0
            assign w_cmp = w_exp;
        end
    endgenerate

    assign o_occ = r_occ;
    assign o_mis = i_chk_en ? (w_cmp ^ i_dut) : 6'b0;
endmodule

module fifo_flag_checker #(
    parameter  int NUM_CH     = 4,
    parameter  int ASIZE      = 4,
    parameter  int AFULL_TH   = 2**ASIZE-2,
    parameter  int AEMPTY_TH  = 2,
    parameter  int FLAG_LAT   = 0,
    parameter  int ERR_CNT_WD = 8,
    localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_chk_en,
    input  logic                          i_err_clr,
    input  logic [NUM_CH-1:0]             i_wen,
    input  logic [NUM_CH-1:0]             i_ren,
    input  logic [NUM_CH-1:0]             i_full,
    input  logic [NUM_CH-1:0]             i_near_full,
    input  logic [NUM_CH-1:0]             i_empty,
    input  logic [NUM_CH-1:0]             i_near_empty,
    input  logic [NUM_CH-1:0]             i_overflow,
    input  logic [NUM_CH-1:0]             i_underflow,
    output logic [NUM_CH*(ASIZE+1)-1:0]   o_occ,
    output logic                          o_err_vld,
    output logic [CHW-1:0]                o_err_ch,
    output logic [5:0]                    o_err_type,
    output logic [NUM_CH-1:0]             o_err_sticky,
    output logic [ERR_CNT_WD-1:0]         o_err_cnt
);
    generate
        if (FLAG_LAT != 0 && FLAG_LAT != 1) begin : g_bad_lat
            $error("fifo_flag_checker: FLAG_LAT must be 0 or 1");
        end
    endgenerate

    logic [NUM_CH-1:0][5:0]     w_dut;
    logic [NUM_CH-1:0][5:0]     w_mis;
    logic [NUM_CH-1:0][ASIZE:0] w_occ;
    logic [NUM_CH-1:0]          w_hit;
    logic                       w_any;
    logic [CHW-1:0]             w_sel_ch;
    logic [5:0]                 w_sel_type;

    logic                       r_err_vld;
    logic [CHW-1:0]             r_err_ch;
    logic [5:0]                 r_err_type;
    logic [NUM_CH-1:0]          r_sticky;
    logic [ERR_CNT_WD-1:0]      r_cnt;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign w_dut[c] = {i_underflow[c], i_overflow[c], i_near_empty[c],
                               i_empty[c], i_near_full[c], i_full[c]};
            fifo_flag_checker_ch #(
                .ASIZE     (ASIZE),
                .AFULL_TH  (AFULL_TH),
                .AEMPTY_TH (AEMPTY_TH),
                .FLAG_LAT  (FLAG_LAT)
            ) u_ch (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_chk_en (i_chk_en),
                .i_wen    (i_wen[c]),
                .i_ren    (i_ren[c]),
                .i_dut    (w_dut[c]),
                .o_occ    (w_occ[c]),
                .o_mis    (w_mis[c])
            );
            assign w_hit[c] = |w_mis[c];
        end
    endgenerate

    // Scan high-to-low so the lowest mismatching channel wins.
    always_comb begin
        w_sel_ch   = '0;
        w_sel_type = '0;
        for (int c = NUM_CH-1; c >= 0; c--) begin
            if (w_hit[c]) begin
                w_sel_ch   = CHW'(c);
                w_sel_type = w_mis[c];
            end
        end
    end

    assign w_any = |w_hit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_vld  <= 1'b0;
            r_err_ch   <= '0;
            r_err_type <= '0;
            r_sticky   <= '0;
            r_cnt      <= '0;
        end else begin
            r_err_vld <= w_any;
            if (w_any) begin
                r_err_ch   <= w_sel_ch;
                r_err_type <= w_sel_type;
            end
            r_sticky <= (i_err_clr ? '0 : r_sticky) | w_hit;
            if (i_err_clr)
                r_cnt <= ERR_CNT_WD'(w_any);
            else if (w_any && r_cnt != '1)
                r_cnt <= r_cnt + ERR_CNT_WD'(1);
        end
    end

    assign o_occ        = w_occ;
    assign o_err_vld    = r_err_vld;
    assign o_err_ch     = r_err_ch;
    assign o_err_type   = r_err_type;
    assign o_err_sticky = r_sticky;
    assign o_err_cnt    = r_cnt;
endmodule
